// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receiver: FSM states, frame geometry and the
// odd-parity helper.
package ps2_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Parity bit a well-behaved device sends for this byte.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_byte_fifo.sv
// Show-ahead synchronous byte FIFO. The head is presented combinationally and
// reads as zero while the FIFO is empty.
module ps2_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A write into a full FIFO is only legal when the head leaves the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, ps2_clk glitch filter, frame
// FSM with stall timeout, and a show-ahead byte FIFO toward the decoder.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int FIFO_DEPTH   = 8,
  parameter int CHECK_PARITY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [PS2_DATA_BITS-1:0]      ps2_data_out,
  output logic                          data_valid,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          pulso_done,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int HF  = FILTER_LEN / 2;
  localparam int TW  = $clog2(TIMEOUT_CYC);
  localparam int BCW = $clog2(PS2_DATA_BITS);

  ps2_state_e               state_q, state_d;
  logic [1:0]               clk_sync_q, clk_sync_d;
  logic [1:0]               dat_sync_q, dat_sync_d;
  logic [FILTER_LEN-1:0]    filt_q, filt_d;
  logic [BCW-1:0]           bitcnt_q, bitcnt_d;
  logic [PS2_DATA_BITS-1:0] byte_q, byte_d;
  logic                     par_q, par_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     done_q, done_d, perr_q, perr_d;
  logic                     ferr_q, ferr_d, ovf_q, ovf_d;
  logic                     strobe, dat, push, pop;
  logic                     f_full, f_empty;

  assign dat = dat_sync_q[1];
  // Older half of the window high, newer half low: one strobe per clean fall.
  assign strobe = (filt_q[FILTER_LEN-1:HF] == '0) && (&filt_q[HF-1:0]);
  assign pop = rd_en & ~f_empty;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    filt_d     = {clk_sync_q[1], filt_q[FILTER_LEN-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    byte_d   = byte_q;
    par_d    = par_q;
    tmo_d    = (strobe || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
    push     = 1'b0;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    ovf_d    = 1'b0;
    if (strobe) begin
      case (state_q)
        ST_IDLE: if (!dat) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
        ST_DATA: begin
          byte_d   = {dat, byte_q[PS2_DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_q == BCW'(PS2_DATA_BITS-1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat)                                             ferr_d = 1'b1;
          else if (CHECK_PARITY != 0 && odd_parity(byte_q) != par_q) perr_d = 1'b1;
          else if (f_full && !pop)                              ovf_d  = 1'b1;
          else begin
            push   = 1'b1;
            done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC-1)) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      byte_d   = '0;
      tmo_d    = '0;
      ferr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= '1;
      bitcnt_q   <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      bitcnt_q   <= bitcnt_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_byte_fifo #(.DATA_W(PS2_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (byte_q),
    .rd_en   (rd_en),
    .rd_data (ps2_data_out),
    .full    (f_full),
    .empty   (f_empty),
    .count   (fifo_count)
  );

  assign data_valid = ~f_empty;
  assign fifo_full  = f_full;
  assign pulso_done = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: two instances (parity checked / ignored) share the pins
// and are compared against per-instance frame-level queue models.
module tb_ps2_rx_fifo;
  import ps2_rx_fifo_pkg::*;

  localparam int TMO   = 400;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data, rd_en;

  logic [7:0]    dout_a, dout_b;
  logic          dv_a, dv_b, full_a, full_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          done_a, perr_a, ferr_a, ovf_a;
  logic          done_b, perr_b, ferr_b, ovf_b;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1)) dut_a (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .ps2_data_out(dout_a), .data_valid(dv_a), .fifo_full(full_a), .fifo_count(cnt_a),
    .pulso_done(done_a), .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a));

  ps2_rx_fifo #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(0)) dut_b (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .ps2_data_out(dout_b), .data_valid(dv_b), .fifo_full(full_b), .fifo_count(cnt_b),
    .pulso_done(done_b), .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b));

  // Observed pulse-cycle counts: index 0 done, 1 parity, 2 frame, 3 overflow.
  int ev_a [4] = '{0, 0, 0, 0};
  int ev_b [4] = '{0, 0, 0, 0};
  int ex_a [4] = '{0, 0, 0, 0};
  int ex_b [4] = '{0, 0, 0, 0};
  logic [7:0] qa[$], qb[$];
  int checks = 0, errors = 0;

  always @(posedge clk) begin
    ev_a[0] <= ev_a[0] + int'(done_a);
    ev_a[1] <= ev_a[1] + int'(perr_a);
    ev_a[2] <= ev_a[2] + int'(ferr_a);
    ev_a[3] <= ev_a[3] + int'(ovf_a);
    ev_b[0] <= ev_b[0] + int'(done_b);
    ev_b[1] <= ev_b[1] + int'(perr_b);
    ev_b[2] <= ev_b[2] + int'(ferr_b);
    ev_b[3] <= ev_b[3] + int'(ovf_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask

  // Frame-level model: the outcome of a whole frame, by priority.
  task automatic model_frame(input logic [7:0] d, input logic pbad, input logic sbad);
    if (sbad) ex_a[2]++;
    else if (pbad) ex_a[1]++;
    else if (qa.size() == DEPTH) ex_a[3]++;
    else begin qa.push_back(d); ex_a[0]++; end
    if (sbad) ex_b[2]++;
    else if (qb.size() == DEPTH) ex_b[3]++;
    else begin qb.push_back(d); ex_b[0]++; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbad, input logic sbad);
    logic [PS2_FRAME_BITS-1:0] f;
    logic par;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f = {~sbad, par ^ pbad, d, 1'b0};
    for (int i = 0; i < PS2_FRAME_BITS; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    cyc(10);
    model_frame(d, pbad, sbad);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] ha, hb;
    ha = (qa.size() != 0) ? qa[0] : 8'h00;
    hb = (qb.size() != 0) ? qb[0] : 8'h00;
    @(negedge clk);
    chk({tag, " a.done"}, ev_a[0], ex_a[0]);
    chk({tag, " a.perr"}, ev_a[1], ex_a[1]);
    chk({tag, " a.ferr"}, ev_a[2], ex_a[2]);
    chk({tag, " a.ovf"},  ev_a[3], ex_a[3]);
    chk({tag, " b.done"}, ev_b[0], ex_b[0]);
    chk({tag, " b.perr"}, ev_b[1], ex_b[1]);
    chk({tag, " b.ferr"}, ev_b[2], ex_b[2]);
    chk({tag, " b.ovf"},  ev_b[3], ex_b[3]);
    chk({tag, " a.count"}, 32'(cnt_a), qa.size());
    chk({tag, " b.count"}, 32'(cnt_b), qb.size());
    chk({tag, " a.valid"}, 32'(dv_a), 32'(qa.size() != 0));
    chk({tag, " b.valid"}, 32'(dv_b), 32'(qb.size() != 0));
    chk({tag, " a.full"}, 32'(full_a), 32'(qa.size() == DEPTH));
    chk({tag, " b.full"}, 32'(full_b), 32'(qb.size() == DEPTH));
    chk({tag, " a.head"}, 32'(dout_a), 32'(ha));
    chk({tag, " b.head"}, 32'(dout_b), 32'(hb));
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (qa.size() != 0) void'(qa.pop_front());
    if (qb.size() != 0) void'(qb.pop_front());
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    cyc(5);
    check_state("reset");
    reset = 1'b0;
    cyc(5);

    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("t1_rx");
    do_read();
    check_state("t1_rd");

    send_frame(8'hF0, 1'b1, 1'b0);
    check_state("t2_par");
    do_read();
    check_state("t2_rd");

    send_frame(8'h5A, 1'b0, 1'b1);
    check_state("t3_stop");
    send_frame(8'h29, 1'b0, 1'b0);
    check_state("t3_next");
    do_read();

    // Stall after four data bits; only the timeout can end this frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    ps2_data = 1'b1;
    cyc(TMO + 200);
    ex_a[2]++; ex_b[2]++;
    check_state("t4_tmo");
    send_frame(8'h76, 1'b0, 1'b0);
    check_state("t4_next");
    do_read();

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_state("t5_full");
    for (int i = 0; i < 8; i++) begin
      do_read();
      check_state("t5_drain");
    end

    // Short lows must not look like edges; a real frame after them must align.
    for (int i = 0; i < 4; i++) begin
      ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(20);
    end
    check_state("t6_glitch");
    send_frame(8'hA5, 1'b0, 1'b0);
    check_state("t6_after_glitch");

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    qa.delete(); qb.delete();
    ps2_data = 1'b1;
    cyc(TMO + 50);
    check_state("t6_reset");
    send_frame(8'h3C, 1'b0, 1'b0);
    check_state("t6_next");

    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic pb, sb;
      d  = 8'($urandom);
      pb = ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 6) == 0);
      send_frame(d, pb, sb);
      if ($urandom_range(0, 2) == 0) do_read();
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
